// File: rtl/gtf_common_qpll_seq.sv
// Per-channel QPLL power-down/reset/lock sequencer: lock qualification,
// timeout retry, failure latch and saturating lock-loss accounting.
module gtf_common_qpll_seq #(
  parameter int unsigned NUM_PLL      = 2,
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned RESET_CYCLES = 32,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 20
) (
  input  logic                 gtf_cm_drpclk,
  input  logic                 gtf_cm_resetn,
  input  logic [NUM_PLL-1:0]   gtf_cm_pll_en,
  input  logic [NUM_PLL-1:0]   gtf_cm_pll_restart,
  input  logic [NUM_PLL-1:0]   gtf_cm_qpll_lock,
  input  logic [NUM_PLL-1:0]   gtf_cm_qpll_refclklost,
  output logic [NUM_PLL-1:0]   gtf_cm_qpll_pd,
  output logic [NUM_PLL-1:0]   gtf_cm_qpll_reset,
  output logic [NUM_PLL-1:0]   gtf_cm_qpll_ready,
  output logic [NUM_PLL-1:0]   gtf_cm_qpll_fail,
  output logic [4*NUM_PLL-1:0] gtf_cm_qpll_retry_cnt,
  output logic [8*NUM_PLL-1:0] gtf_cm_qpll_lost_cnt
);

  localparam int unsigned RW = 4;
  localparam int unsigned LW = 8;

  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_READY     = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  state_e           state_q [NUM_PLL];
  state_e           state_d [NUM_PLL];
  logic [CNT_W-1:0] timer_q [NUM_PLL];
  logic [CNT_W-1:0] timer_d [NUM_PLL];
  logic [RW-1:0]    retry_q [NUM_PLL];
  logic [RW-1:0]    retry_d [NUM_PLL];
  logic [LW-1:0]    lost_q  [NUM_PLL];
  logic [LW-1:0]    lost_d  [NUM_PLL];

  logic [NUM_PLL-1:0] lock_m_q, lock_s_q, rcl_m_q, rcl_s_q;
  logic [NUM_PLL-1:0] pd_d, pd_q, rst_d, rst_q, ready_d, ready_q, fail_d, fail_q;

  // Double-flop synchronisers for the asynchronous QPLL status pins.
  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_resetn) begin
    if (!gtf_cm_resetn) begin
      lock_m_q <= '0;
      lock_s_q <= '0;
      rcl_m_q  <= '0;
      rcl_s_q  <= '0;
    end else begin
      lock_m_q <= gtf_cm_qpll_lock;
      lock_s_q <= lock_m_q;
      rcl_m_q  <= gtf_cm_qpll_refclklost;
      rcl_s_q  <= rcl_m_q;
    end
  end

  // Channel state, timers, counters and output registers.
  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_resetn) begin
    if (!gtf_cm_resetn) begin
      for (int unsigned i = 0; i < NUM_PLL; i++) begin
        state_q[i] <= S_OFF;
        timer_q[i] <= '0;
        retry_q[i] <= '0;
        lost_q[i]  <= '0;
      end
      pd_q    <= '1;
      rst_q   <= '1;
      ready_q <= '0;
      fail_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PLL; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        retry_q[i] <= retry_d[i];
        lost_q[i]  <= lost_d[i];
      end
      pd_q    <= pd_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they move with it.
  always_comb begin
    logic att_fail;
    logic tmr_clr;
    pd_d    = '1;
    rst_d   = '1;
    ready_d = '0;
    fail_d  = '0;
    for (int unsigned i = 0; i < NUM_PLL; i++) begin
      state_d[i] = state_q[i];
      retry_d[i] = retry_q[i];
      lost_d[i]  = lost_q[i];
      att_fail   = 1'b0;
      tmr_clr    = 1'b0;

      if (!gtf_cm_pll_en[i]) begin
        state_d[i] = S_OFF;
        retry_d[i] = '0;
        tmr_clr    = 1'b1;
      end else if (gtf_cm_pll_restart[i] && (state_q[i] != S_OFF)) begin
        state_d[i] = S_RESET;
        retry_d[i] = '0;
        tmr_clr    = 1'b1;
      end else if (rcl_s_q[i] && ((state_q[i] == S_WAIT_LOCK) || (state_q[i] == S_STABLE))) begin
        state_d[i] = S_RESET;
      end else if (rcl_s_q[i] && (state_q[i] == S_READY)) begin
        state_d[i] = S_RESET;
        retry_d[i] = '0;
        lost_d[i]  = (lost_q[i] == '1) ? lost_q[i] : lost_q[i] + LW'(1);
      end else begin
        case (state_q[i])
          S_OFF: begin
            if (timer_q[i] >= PD_LAST) state_d[i] = S_RESET;
          end
          S_RESET: begin
            // A missing refclk parks the reset pulse at its start.
            if (rcl_s_q[i])                   tmr_clr    = 1'b1;
            else if (timer_q[i] == RST_LAST)  state_d[i] = S_WAIT_LOCK;
          end
          S_WAIT_LOCK: begin
            if (lock_s_q[i])                      state_d[i] = S_STABLE;
            else if (timer_q[i] == TIMEOUT_LAST)  att_fail   = 1'b1;
          end
          S_STABLE: begin
            if (!lock_s_q[i])                    att_fail   = 1'b1;
            else if (timer_q[i] == STABLE_LAST)  state_d[i] = S_READY;
          end
          S_READY: begin
            if (!lock_s_q[i]) begin
              state_d[i] = S_RESET;
              retry_d[i] = '0;
              lost_d[i]  = (lost_q[i] == '1) ? lost_q[i] : lost_q[i] + LW'(1);
            end
          end
          S_FAIL:  state_d[i] = S_FAIL;
          default: state_d[i] = S_OFF;
        endcase
      end

      if (att_fail) begin
        if (retry_q[i] < RETRY_MAX) begin
          retry_d[i] = retry_q[i] + RW'(1);
          state_d[i] = S_RESET;
        end else begin
          retry_d[i] = RETRY_MAX;
          state_d[i] = S_FAIL;
        end
      end

      if (tmr_clr || (state_d[i] != state_q[i])) timer_d[i] = '0;
      else if (timer_q[i] == '1)                 timer_d[i] = timer_q[i];
      else                                       timer_d[i] = timer_q[i] + CNT_W'(1);

      pd_d[i]    = (state_d[i] == S_OFF);
      rst_d[i]   = (state_d[i] == S_OFF) || (state_d[i] == S_RESET) || (state_d[i] == S_FAIL);
      ready_d[i] = (state_d[i] == S_READY);
      fail_d[i]  = (state_d[i] == S_FAIL);
    end
  end

  assign gtf_cm_qpll_pd    = pd_q;
  assign gtf_cm_qpll_reset = rst_q;
  assign gtf_cm_qpll_ready = ready_q;
  assign gtf_cm_qpll_fail  = fail_q;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_pack
    assign gtf_cm_qpll_retry_cnt[RW*g +: RW] = retry_q[g];
    assign gtf_cm_qpll_lost_cnt[LW*g +: LW]  = lost_q[g];
  end

endmodule

// File: tb/tb_gtf_common_qpll_seq.sv
// Self-checking bench for gtf_common_qpll_seq: scenario tasks with inline
// checks and a small expected-value queue popped on DUT output events.
module tb_gtf_common_qpll_seq;

  localparam int unsigned NP = 2;
  localparam int unsigned PD = 4;
  localparam int unsigned RC = 8;
  localparam int unsigned LT = 100;
  localparam int unsigned LS = 16;
  localparam int unsigned MR = 2;
  localparam int unsigned CW = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  en, restart, lock, rcl;
  logic [1:0]  pd, rs, rdy, fl;
  logic [7:0]  rc;
  logic [15:0] lc;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  gtf_common_qpll_seq #(
    .NUM_PLL(NP), .PD_CYCLES(PD), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
    .LOCK_STABLE(LS), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .gtf_cm_drpclk(clk),
    .gtf_cm_resetn(rstn),
    .gtf_cm_pll_en(en),
    .gtf_cm_pll_restart(restart),
    .gtf_cm_qpll_lock(lock),
    .gtf_cm_qpll_refclklost(rcl),
    .gtf_cm_qpll_pd(pd),
    .gtf_cm_qpll_reset(rs),
    .gtf_cm_qpll_ready(rdy),
    .gtf_cm_qpll_fail(fl),
    .gtf_cm_qpll_retry_cnt(rc),
    .gtf_cm_qpll_lost_cnt(lc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] e, input logic [1:0] r, input logic [1:0] l);
    rstn = 1'b0; en = e; restart = '0; lock = l; rcl = r;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; en = 2'b11; restart = '0; lock = 2'b11; rcl = '0;
    #23;
    checks++;
    if ({pd, rs, rdy, fl} !== 8'b1111_0000) begin
      errors++;
      $display("FAIL reset_ctl: pd=%b rst=%b rdy=%b fail=%b, want 11 11 00 00", pd, rs, rdy, fl);
    end
    checks++;
    if (rc !== 8'h00 || lc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cnt: retry=%h lost=%h, want 00 0000", rc, lc);
    end
  endtask

  task automatic test_bringup;
    int bad, hi;
    do_reset(2'b01, 2'b00, 2'b00);
    bad = 0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      if (pd[0] !== 1'b1) bad++;
    end
    tick(1);
    checks++;
    if (bad != 0 || pd[0] !== 1'b0) begin
      errors++;
      $display("FAIL pd_fall: pd0=%b early_falls=%0d, want pd0 falling at edge 4", pd[0], bad);
    end
    hi = (rs[0] === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (rs[0] === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi != RC) begin
      errors++;
      $display("FAIL rst_width: got %0d cycles, want %0d", hi, RC);
    end
    tick(20);
    lock = 2'b01;
    exp_q.push_back(0);
    bad = 0;
    for (int c = 0; c < 18; c++) begin
      tick(1);
      if (rdy[0] !== 1'b0) bad++;
    end
    tick(1);
    checks++;
    if (bad != 0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL lock_latency: rdy0=%b early=%0d, want ready at 19th edge", rdy[0], bad);
    end
    checks++;
    if (int'(rc[3:0]) != exp_q.pop_front()) begin
      errors++;
      $display("FAIL ready_retry: retry0=%0d, want 0", rc[3:0]);
    end
    checks++;
    if (pd[1] !== 1'b1 || rs[1] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL ch1_idle: pd1=%b rst1=%b rdy1=%b, want 1 1 0", pd[1], rs[1], rdy[1]);
    end
  endtask

  task automatic test_timeout;
    int pulses, hi, lo;
    logic prev_rs;
    do_reset(2'b01, 2'b00, 2'b00);
    pulses = 0; hi = 0; lo = 0; prev_rs = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tick(1);
      if (pd[0] === 1'b1) continue;
      if (rs[0] === 1'b1) begin
        if (!prev_rs) begin
          checks++;
          if (lo != LT) begin
            errors++;
            $display("FAIL wait_len: got %0d cycles, want %0d", lo, LT);
          end
          if (fl[0] !== 1'b1) begin
            checks++;
            if (int'(rc[3:0]) != pulses) begin
              errors++;
              $display("FAIL retry_step: retry0=%0d, want %0d", rc[3:0], pulses);
            end
          end
          lo = 0;
        end
        hi++;
      end else begin
        if (prev_rs) begin
          checks++;
          if (hi != RC) begin
            errors++;
            $display("FAIL pulse_len: got %0d cycles, want %0d", hi, RC);
          end
          pulses++;
          hi = 0;
        end
        lo++;
      end
      prev_rs = rs[0];
      if (fl[0] === 1'b1) break;
    end
    checks++;
    if (pulses != 3 || fl[0] !== 1'b1 || rs[0] !== 1'b1 || rc[3:0] !== 4'd2) begin
      errors++;
      $display("FAIL fail_state: pulses=%0d fail0=%b rst0=%b retry0=%0d, want 3 1 1 2",
               pulses, fl[0], rs[0], rc[3:0]);
    end
  endtask

  task automatic test_restart_fail;
    int hi;
    restart = 2'b01;
    tick(1);
    restart = 2'b00;
    checks++;
    if (fl[0] !== 1'b0 || rs[0] !== 1'b1 || rc[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL restart: fail0=%b rst0=%b retry0=%0d, want 0 1 0", fl[0], rs[0], rc[3:0]);
    end
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (rs[0] === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi != RC) begin
      errors++;
      $display("FAIL restart_width: got %0d cycles, want %0d", hi, RC);
    end
  endtask

  task automatic test_en_drop;
    tick(10);
    en = 2'b00;
    tick(1);
    checks++;
    if (pd[0] !== 1'b1 || rs[0] !== 1'b1 || rc[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL en_drop: pd0=%b rst0=%b retry0=%0d, want 1 1 0", pd[0], rs[0], rc[3:0]);
    end
    en = 2'b01;
  endtask

  task automatic test_stable_glitch;
    int hi, n;
    do_reset(2'b01, 2'b00, 2'b00);
    tick(12);
    lock = 2'b01;
    tick(12);
    lock = 2'b00;
    exp_q.push_back(1);
    tick(1);
    lock = 2'b01;
    tick(1);
    checks++;
    if (rs[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early: rst0=%b rdy0=%b, want 0 0", rs[0], rdy[0]);
    end
    tick(1);
    checks++;
    if (rs[0] !== 1'b1 || rc[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL glitch_retry: rst0=%b retry0=%0d, want 1 1", rs[0], rc[3:0]);
    end
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (rs[0] === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi != RC) begin
      errors++;
      $display("FAIL glitch_rst_width: got %0d cycles, want %0d", hi, RC);
    end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      n++;
      if (rdy[0] === 1'b1) break;
    end
    checks++;
    if (n != LS + 1 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_relock: ready after %0d edges (rdy0=%b), want %0d", n, rdy[0], LS + 1);
    end
    checks++;
    if (int'(rc[3:0]) != exp_q.pop_front()) begin
      errors++;
      $display("FAIL glitch_hold: retry0=%0d in READY, want 1", rc[3:0]);
    end
  endtask

  task automatic test_lock_loss;
    int hi, n;
    bit ok;
    for (int k = 1; k <= 3; k++) begin
      lock = 2'b00;
      exp_q.push_back(k);
      tick(2);
      checks++;
      if (rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL loss_early: loss %0d rdy0=%b after 2 edges, want 1", k, rdy[0]);
      end
      tick(1);
      checks++;
      if (rdy[0] !== 1'b0 || rs[0] !== 1'b1 || int'(lc[7:0]) != exp_q.pop_front() || rc[3:0] !== 4'd0) begin
        errors++;
        $display("FAIL loss_event: loss %0d rdy0=%b rst0=%b lost0=%0d retry0=%0d, want 0 1 %0d 0",
                 k, rdy[0], rs[0], lc[7:0], rc[3:0], k);
      end
      lock = 2'b01;
      hi = 1;
      for (int c = 0; c < 20; c++) begin
        tick(1);
        if (rs[0] === 1'b1) hi++;
        else break;
      end
      n = 0;
      for (int c = 0; c < 40 && rdy[0] !== 1'b1; c++) begin
        tick(1);
        n++;
      end
      checks++;
      if (hi != RC || rdy[0] !== 1'b1 || rc[3:0] !== 4'd0) begin
        errors++;
        $display("FAIL loss_recover: loss %0d rst_width=%0d rdy0=%b retry0=%0d, want %0d 1 0",
                 k, hi, rdy[0], rc[3:0], RC);
      end
    end
    ok = 1'b1;
    for (int k = 0; k < 300 && ok; k++) begin
      lock = 2'b00;
      for (int c = 0; c < 10 && rdy[0] !== 1'b0; c++) tick(1);
      lock = 2'b01;
      for (int c = 0; c < 60 && rdy[0] !== 1'b1; c++) tick(1);
      if (rdy[0] !== 1'b1) begin
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL sat_relock: no READY after forced loss %0d", k);
      end
      if (k == 99) begin
        checks++;
        if (lc[7:0] !== 8'd103) begin
          errors++;
          $display("FAIL lost_mid: lost0=%0d, want 103", lc[7:0]);
        end
      end
    end
    checks++;
    if (lc[7:0] !== 8'd255 || lc[15:8] !== 8'd0) begin
      errors++;
      $display("FAIL lost_sat: lost0=%0d lost1=%0d, want 255 0", lc[7:0], lc[15:8]);
    end
  endtask

  task automatic test_async_reset;
    lock = 2'b00;
    tick(3);
    lock = 2'b01;
    tick(8);
    tick(5);
    checks++;
    if (rs[0] !== 1'b0 || rdy[0] !== 1'b0 || lc[7:0] !== 8'd255) begin
      errors++;
      $display("FAIL pre_async: rst0=%b rdy0=%b lost0=%0d, want 0 0 255", rs[0], rdy[0], lc[7:0]);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({pd, rs, rdy, fl} !== 8'b1111_0000 || rc !== 8'h00 || lc !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: pd=%b rst=%b rdy=%b fail=%b retry=%h lost=%h, want 11 11 00 00 00 0000",
               pd, rs, rdy, fl, rc, lc);
    end
    tick(2);
  endtask

  task automatic test_refclk;
    int bad, n;
    do_reset(2'b11, 2'b10, 2'b01);
    bad = 0;
    for (int c = 1; c <= 200; c++) begin
      tick(1);
      if (c >= 4 && !(pd[1] === 1'b0 && rs[1] === 1'b1)) bad++;
    end
    checks++;
    if (bad != 0 || rc[7:4] !== 4'd0) begin
      errors++;
      $display("FAIL refclk_hold: ch1 left RESET %0d times, retry1=%0d, want 0 0", bad, rc[7:4]);
    end
    checks++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL refclk_ch0: rdy=%b, want 01", rdy);
    end
    rcl = 2'b00;
    lock = 2'b11;
    n = 0;
    for (int c = 0; c < 30 && rs[1] !== 1'b0; c++) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != RC + 2) begin
      errors++;
      $display("FAIL refclk_release: reset1 fell after %0d edges, want %0d", n, RC + 2);
    end
    n = 0;
    for (int c = 0; c < 40 && rdy[1] !== 1'b1; c++) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != LS + 1 || rc[7:4] !== 4'd0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL refclk_ready: ch1 ready after %0d edges retry1=%0d rdy0=%b, want %0d 0 1",
               n, rc[7:4], rdy[0], LS + 1);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_timeout();
    test_restart_fail();
    test_en_drop();
    test_stable_glitch();
    test_lock_loss();
    test_async_reset();
    test_refclk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
